// File: rtl/branch_predictor_2b.sv
// branch_predictor_2b
//   Dynamic branch direction predictor built from a table of 2-bit saturating
//   counters. The table is indexed by the fetch PC (bimodal) or by the fetch PC
//   XOR a global history register (gshare). Resolved EX outcomes train the
//   table, and resolved branches and mispredictions are counted for statistics.
//
//   Optional feature macro: BRANCH_PREDICTOR_GSHARE_EN
//     defined   : IDX_W-bit GHR, pred_idx = lookup_pc[IDX_W+1:2] ^ ghr
//     undefined : no GHR, pred_idx = lookup_pc[IDX_W+1:2] (pure bimodal)
//
// Parameters
//   IDX_W : table index width, table has 2^IDX_W counters
//   PC_W  : PC width
//   CNT_W : statistics counter width
//
// Ports
//   clk           in  : clock, rising edge
//   rst           in  : asynchronous active-high reset
//   lookup_pc     in  : PC of the instruction in fetch
//   predict_taken out : predicted direction (next-PC mux select), combinational
//   pred_idx      out : table index used by this lookup, combinational
//   upd_valid     in  : a conditional branch resolved in EX this cycle
//   upd_idx       in  : pred_idx carried with the resolving branch
//   upd_taken     in  : actual outcome
//   upd_pred      in  : prediction made for that branch
//   mispredict    out : upd_valid & (upd_taken != upd_pred), combinational
//   br_count      out : saturating count of resolved branches
//   miss_count    out : saturating count of mispredictions

module branch_predictor_2b #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             predict_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned TBL_N = 32'(1) << IDX_W;

  // Counter encodings
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Prediction counter table
  logic [1:0] ctr_q [TBL_N];

  // Next value of the entry addressed by upd_idx
  logic [1:0] ctr_cur;
  logic [1:0] ctr_nxt;

  // Lookup index derivation
  logic [IDX_W-1:0] base_idx;

  // Word-aligned PC: low two bits and bits above the index never select an entry
  logic unused_pc;

  assign base_idx  = lookup_pc[IDX_W+1:2];
  assign unused_pc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  // Global history, trained only by resolved (non-speculative) outcomes
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_nxt;

  // Shift the newest outcome into bit 0
  always_comb begin
    ghr_nxt = ghr_q;
    if (upd_valid) begin
      ghr_nxt = (ghr_q << 1) | IDX_W'(upd_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_nxt;
    end
  end

  assign pred_idx = base_idx ^ ghr_q;
`else
  assign pred_idx = base_idx;
`endif

  // Read-old: a same-cycle update to this entry becomes visible next cycle
  assign predict_taken = ctr_q[pred_idx][1];

  assign mispredict = upd_valid & (upd_taken ^ upd_pred);

  // Saturating increment/decrement of the trained entry
  always_comb begin
    ctr_cur = ctr_q[upd_idx];
    ctr_nxt = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_ST) begin
        ctr_nxt = ctr_cur + 2'(1);
      end
    end else begin
      if (ctr_cur != CTR_SNT) begin
        ctr_nxt = ctr_cur - 2'(1);
      end
    end
  end

  // Table storage: reset puts every entry at weak not-taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TBL_N; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= ctr_nxt;
    end
  end

  // Statistics next-state, holding at all-ones instead of wrapping
  logic [CNT_W-1:0] br_nxt;
  logic [CNT_W-1:0] miss_nxt;

  always_comb begin
    br_nxt   = br_count;
    miss_nxt = miss_count;
    if (upd_valid && (br_count != CNT_MAX)) begin
      br_nxt = br_count + CNT_W'(1);
    end
    if (mispredict && (miss_count != CNT_MAX)) begin
      miss_nxt = miss_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      br_count   <= br_nxt;
      miss_count <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor_2b.sv
// Scoreboard bench for branch_predictor_2b: the stimulus process drives one
// cycle at a time and queues the expected responses for that cycle; the
// monitor drains the queue on the falling edge and compares against the DUT.

module tb_branch_predictor_2b;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  localparam int SEL_PRED = 0;
  localparam int SEL_IDX  = 1;
  localparam int SEL_BR   = 2;
  localparam int SEL_MISS = 3;
  localparam int SEL_MISP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  lookup_pc;
  logic             predict_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_pred;
  logic             mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] miss_count;

  branch_predictor_2b #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (lookup_pc),
    .predict_taken (predict_taken),
    .pred_idx      (pred_idx),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .upd_pred      (upd_pred),
    .mispredict    (mispredict),
    .br_count      (br_count),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } chk_t;

  chk_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_ghr  = 4'd0;   // history the bench expects the DUT to hold

  function automatic logic [3:0] eff_ghr();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return m_ghr;
`else
    return 4'd0;
`endif
  endfunction

  // Lookup PC that lands on table entry idx given the current history
  function automatic logic [PC_W-1:0] pc_for(input logic [3:0] idx);
    logic [3:0] b;
    b = idx ^ eff_ghr();
    return PC_W'({b, 2'b00});
  endfunction

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic expect_v(input string name, input int sel, input int exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic expect_all(input string name, input int p, input int idx,
                            input int br, input int miss, input int misp);
    if (p >= 0)   expect_v({name, "_pred"}, SEL_PRED, p);
    if (idx >= 0) expect_v({name, "_idx"},  SEL_IDX,  idx);
    expect_v({name, "_br"},   SEL_BR,   br);
    expect_v({name, "_miss"}, SEL_MISS, miss);
    expect_v({name, "_misp"}, SEL_MISP, misp);
  endtask

  task automatic drive(input logic [PC_W-1:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut, input logic up);
    lookup_pc = pc;
    upd_valid = uv;
    upd_idx   = ui;
    upd_taken = ut;
    upd_pred  = up;
  endtask

  // Advance one cycle; inputs are stable at the edge so the history model sees them
  task automatic tick();
    @(posedge clk);
    if (upd_valid && !rst) m_ghr = {m_ghr[2:0], upd_taken};
    #1;
  endtask

  // Monitor: compare every response queued for this cycle
  chk_t mon_c;
  int   mon_act;
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      mon_c = sb.pop_front();
      case (mon_c.sel)
        SEL_PRED: mon_act = int'(predict_taken);
        SEL_IDX:  mon_act = int'(pred_idx);
        SEL_BR:   mon_act = int'(br_count);
        SEL_MISS: mon_act = int'(miss_count);
        default:  mon_act = int'(mispredict);
      endcase
      checks++;
      if (mon_act != mon_c.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", mon_c.name, mon_act, mon_c.exp, $time);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset sweep: every entry weak not-taken, counters clear
    for (int i = 0; i < 16; i++) begin
      drive(PC_W'(i * 4), 1'b0, 4'd0, 1'b0, 1'b0);
      expect_all($sformatf("rst_pc%0d", i * 4), 0, i, 0, 0, 0);
      tick();
    end
    rst = 1'b0;
    tick();

    // Train idx 3 to taken with two mispredicting updates; lookup reads old value
    drive(pc_for(3), 1'b1, 4'd3, 1'b1, 1'b0);
    expect_all("train0", 0, 3, 0, 0, 1);
    tick();
    drive(pc_for(3), 1'b1, 4'd3, 1'b1, 1'b0);
    expect_all("train1", 1, 3, 1, 1, 1);
    tick();
    drive(pc_for(3), 1'b0, 4'd0, 1'b0, 1'b0);
    expect_all("train_done", 1, 3, 2, 2, 0);
    tick();

    // Saturate at strong taken
    for (int j = 0; j < 5; j++) begin
      drive(pc_for(3), 1'b1, 4'd3, 1'b1, 1'b1);
      expect_all($sformatf("sat_t%0d", j), 1, 3, 2 + j, 2, 0);
      tick();
    end
    drive(pc_for(3), 1'b1, 4'd3, 1'b0, 1'b1);
    expect_all("nt_first", 1, 3, 7, 2, 1);
    tick();
    drive(pc_for(3), 1'b0, 4'd0, 1'b0, 1'b0);
    expect_all("after_nt1", 1, 3, 8, 3, 0);
    tick();

    // Walk down to strong not-taken: 10 -> 01 -> 00 -> 00
    for (int j = 0; j < 3; j++) begin
      drive(pc_for(3), 1'b1, 4'd3, 1'b0, 1'b0);
      expect_all($sformatf("sat_nt%0d", j), (j == 0) ? 1 : 0, 3, 8 + j, 3, 0);
      tick();
    end
    // One taken from 00 reaches only 01, so prediction stays not-taken
    drive(pc_for(3), 1'b1, 4'd3, 1'b1, 1'b0);
    expect_all("from00", 0, 3, 11, 3, 1);
    tick();

    // Same-cycle lookup and update from 01: old value now, new value next cycle
    drive(pc_for(3), 1'b1, 4'd3, 1'b1, 1'b0);
    expect_all("rw_same", 0, 3, 12, 4, 1);
    tick();
    drive(pc_for(3), 1'b0, 4'd0, 1'b0, 1'b0);
    expect_all("rw_next", 1, 3, 13, 5, 0);
    tick();

    // Statistics saturate at 15 with CNT_W=4
    for (int k = 0; k < 20; k++) begin
      drive(pc_for(3), 1'b1, 4'd5, 1'b1, 1'b0);
      expect_all($sformatf("stat%0d", k), -1, -1, sat(13 + k), sat(5 + k), 1);
      tick();
    end
    drive(pc_for(3), 1'b0, 4'd0, 1'b0, 1'b0);
    expect_all("stat_hold", 1, 3, 15, 15, 0);
    tick();

    // Asynchronous reset between edges: state clears before any clock edge
    rst   = 1'b1;
    m_ghr = 4'd0;
    drive(pc_for(3), 1'b0, 4'd0, 1'b0, 1'b0);
    expect_all("async_rst", 0, 3, 0, 0, 0);
    tick();
    drive(pc_for(5), 1'b0, 4'd0, 1'b0, 1'b0);
    expect_all("rst_idx5", 0, 5, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Two taken updates give history 0011; PC 0x10 then maps to 0111 under gshare
    drive(PC_W'(32'h10), 1'b1, 4'd9, 1'b1, 1'b0);
    expect_all("gh0", -1, -1, 0, 0, 1);
    tick();
    drive(PC_W'(32'h10), 1'b1, 4'd9, 1'b1, 1'b0);
    expect_all("gh1", -1, -1, 1, 1, 1);
    tick();
    drive(PC_W'(32'h10), 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    expect_all("gh_idx", 0, 7, 2, 2, 0);
`else
    expect_all("gh_idx", 0, 4, 2, 2, 0);
`endif
    tick();

    // Let the monitor drain the last cycle
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
